// File: rtl/snf_retryackq_pkg.sv
// Shared field layout and defaults for the SN-F RetryAck queue.
// Record layout matches the TXRSP unpacker exactly.
package snf_retryackq_pkg;

    localparam int SNF_RETRY_ACKQ_DEPTH_PARAM = 8;
    localparam int SNF_RETRY_ACKQ_DATA_W      = 32;

    localparam int SNF_RETRY_ACKQ_TRACE_LSB    = 0;
    localparam int SNF_RETRY_ACKQ_PCRDTYPE_LSB = 1;
    localparam int SNF_RETRY_ACKQ_TXNID_LSB    = 5;
    localparam int SNF_RETRY_ACKQ_SRCID_LSB    = 17;
    localparam int SNF_RETRY_ACKQ_QOS_LSB      = 28;

    typedef struct packed {
        logic [3:0]  qos;
        logic [10:0] srcid;
        logic [11:0] txnid;
        logic [3:0]  pcrdtype;
        logic        tracetag;
    } retry_rec_t;

    function automatic logic [31:0] pack_rec(
        input logic [3:0]  qos,
        input logic [10:0] srcid,
        input logic [11:0] txnid,
        input logic [3:0]  pcrdtype,
        input logic        tracetag
    );
        retry_rec_t r;
        r.qos      = qos;
        r.srcid    = srcid;
        r.txnid    = txnid;
        r.pcrdtype = pcrdtype;
        r.tracetag = tracetag;
        return r;
    endfunction

endpackage

// File: rtl/snf_retryackq_if.sv
// Push side from request acceptance and pop side from the TXRSP arbiter.
// The queue uses the slave modport; its neighbours use master.
interface snf_retryackq_if;

    logic        retry_push_s0;
    logic [3:0]  retry_qos_s0;
    logic [10:0] retry_srcid_s0;
    logic [11:0] retry_txnid_s0;
    logic [3:0]  retry_pcrdtype_s0;
    logic        retry_tracetag_s0;
    logic        retry_ready_s0;
    logic        qos_txrsp_retryack_valid_s1;
    logic [31:0] qos_txrsp_retryack_fifo_s1;
    logic        txrsp_retryack_won_s1;

    modport slave (
        input  retry_push_s0,
        input  retry_qos_s0,
        input  retry_srcid_s0,
        input  retry_txnid_s0,
        input  retry_pcrdtype_s0,
        input  retry_tracetag_s0,
        output retry_ready_s0,
        output qos_txrsp_retryack_valid_s1,
        output qos_txrsp_retryack_fifo_s1,
        input  txrsp_retryack_won_s1
    );

    modport master (
        output retry_push_s0,
        output retry_qos_s0,
        output retry_srcid_s0,
        output retry_txnid_s0,
        output retry_pcrdtype_s0,
        output retry_tracetag_s0,
        input  retry_ready_s0,
        input  qos_txrsp_retryack_valid_s1,
        input  qos_txrsp_retryack_fifo_s1,
        output txrsp_retryack_won_s1
    );

endinterface

// File: rtl/snf_sync_fifo.sv
// Generic synchronous FIFO: unreset storage, wrapping pointers, occupancy.
// DEPTH need not be a power of two.
module snf_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= nxt(wr_ptr);
            if (pop_ok)
                rd_ptr <= nxt(rd_ptr);
            if (push_ok & ~pop_ok)
                cnt <= cnt + CNT_W'(1);
            else if (pop_ok & ~push_ok)
                cnt <= cnt - CNT_W'(1);
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/snf_retryackq.sv
// RetryAck queue feeding the TXRSP arbiter as its top-priority source.
// Strict FIFO; sticky error on push-when-full or won-when-empty.
module snf_retryackq
    import snf_retryackq_pkg::*;
#(
    parameter int DEPTH = SNF_RETRY_ACKQ_DEPTH_PARAM,
    parameter int CNT_W = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    snf_retryackq_if.slave   bus,
    output logic [CNT_W-1:0] retryackq_cnt,
    output logic             retryackq_err
);

    logic [31:0] rec;
    logic        full;
    logic        empty;

    assign rec = pack_rec(bus.retry_qos_s0, bus.retry_srcid_s0,
                          bus.retry_txnid_s0, bus.retry_pcrdtype_s0,
                          bus.retry_tracetag_s0);

    snf_sync_fifo #(
        .WIDTH (SNF_RETRY_ACKQ_DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.retry_push_s0),
        .wdata (rec),
        .pop   (bus.txrsp_retryack_won_s1),
        .rdata (bus.qos_txrsp_retryack_fifo_s1),
        .full  (full),
        .empty (empty),
        .cnt   (retryackq_cnt)
    );

    assign bus.retry_ready_s0              = ~full;
    assign bus.qos_txrsp_retryack_valid_s1 = ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            retryackq_err <= 1'b0;
        else if ((bus.retry_push_s0 & full) |
                 (bus.txrsp_retryack_won_s1 & empty))
            retryackq_err <= 1'b1;
    end

endmodule

// File: tb/tb_snf_retryackq.sv
// Bench for snf_retryackq: DEPTH=8 and DEPTH=5 instances share stimulus
// and are each compared against a queue-based reference model.
module tb_snf_retryackq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        push = 1'b0;
    logic        won  = 1'b0;
    logic [3:0]  qos  = '0;
    logic [10:0] srcid = '0;
    logic [11:0] txnid = '0;
    logic [3:0]  pcrd = '0;
    logic        tt   = 1'b0;

    snf_retryackq_if if8();
    snf_retryackq_if if5();

    logic [3:0] cnt8;
    logic [2:0] cnt5;
    logic       err8;
    logic       err5;

    assign if8.retry_push_s0         = push;
    assign if8.retry_qos_s0          = qos;
    assign if8.retry_srcid_s0        = srcid;
    assign if8.retry_txnid_s0        = txnid;
    assign if8.retry_pcrdtype_s0     = pcrd;
    assign if8.retry_tracetag_s0     = tt;
    assign if8.txrsp_retryack_won_s1 = won;
    assign if5.retry_push_s0         = push;
    assign if5.retry_qos_s0          = qos;
    assign if5.retry_srcid_s0        = srcid;
    assign if5.retry_txnid_s0        = txnid;
    assign if5.retry_pcrdtype_s0     = pcrd;
    assign if5.retry_tracetag_s0     = tt;
    assign if5.txrsp_retryack_won_s1 = won;

    snf_retryackq #(.DEPTH(8)) u_d8 (
        .clk           (clk),
        .rst           (rst),
        .bus           (if8),
        .retryackq_cnt (cnt8),
        .retryackq_err (err8)
    );

    snf_retryackq #(.DEPTH(5)) u_d5 (
        .clk           (clk),
        .rst           (rst),
        .bus           (if5),
        .retryackq_cnt (cnt5),
        .retryackq_err (err5)
    );

    logic [5:0]  c_o [2];
    logic        r_o [2];
    logic        v_o [2];
    logic        e_o [2];
    logic [31:0] f_o [2];

    assign c_o[0] = 6'(cnt8);
    assign c_o[1] = 6'(cnt5);
    assign r_o[0] = if8.retry_ready_s0;
    assign r_o[1] = if5.retry_ready_s0;
    assign v_o[0] = if8.qos_txrsp_retryack_valid_s1;
    assign v_o[1] = if5.qos_txrsp_retryack_valid_s1;
    assign e_o[0] = err8;
    assign e_o[1] = err5;
    assign f_o[0] = if8.qos_txrsp_retryack_fifo_s1;
    assign f_o[1] = if5.qos_txrsp_retryack_fifo_s1;

    int          dep [2] = '{8, 5};
    logic [31:0] mq [2][$];
    bit          merr [2];
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all();
        for (int k = 0; k < 2; k++) begin
            int sz;
            sz = mq[k].size();
            chk($sformatf("d%0d_cnt", dep[k]), 32'(c_o[k]), 32'(sz));
            chk($sformatf("d%0d_ready", dep[k]), 32'(r_o[k]),
                32'(sz != dep[k]));
            chk($sformatf("d%0d_valid", dep[k]), 32'(v_o[k]), 32'(sz != 0));
            chk($sformatf("d%0d_err", dep[k]), 32'(e_o[k]), 32'(merr[k]));
            if (sz != 0)
                chk($sformatf("d%0d_head", dep[k]), f_o[k], mq[k][0]);
        end
    endtask

    task automatic set_rec(input logic [3:0] q, input logic [10:0] s,
                           input logic [11:0] t, input logic [3:0] pc,
                           input logic g);
        qos = q; srcid = s; txnid = t; pcrd = pc; tt = g;
    endtask

    task automatic rnd_rec();
        set_rec(4'($urandom), 11'($urandom), 12'($urandom),
                4'($urandom), 1'($urandom));
    endtask

    // One clock: check current state, apply inputs, advance model.
    task automatic cyc(input bit p, input bit w);
        logic [31:0] rec;
        chk_all();
        push = p;
        won  = w;
        rec  = {qos, srcid, txnid, pcrd, tt};
        for (int k = 0; k < 2; k++) begin
            int sz;
            sz = mq[k].size();
            if ((p && sz == dep[k]) || (w && sz == 0))
                merr[k] = 1'b1;
            if (w && sz > 0)
                void'(mq[k].pop_front());
            if (p && sz < dep[k])
                mq[k].push_back(rec);
        end
        @(posedge clk);
        #1;
        push = 1'b0;
        won  = 1'b0;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            merr[k] = 1'b0;
        end
    endtask

    task automatic do_reset();
        push = 1'b0;
        won  = 1'b0;
        rst  = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        chk_all();
        rst = 1'b0;
    endtask

    initial begin
        model_clear();
        #1;
        do_reset();

        set_rec(4'h3, 11'h012, 12'h0A5, 4'h1, 1'b1);
        cyc(1, 0);
        chk("pack", f_o[0], 32'h3024_14A3);
        chk("pack_cnt", 32'(c_o[0]), 32'd1);
        cyc(0, 1);
        chk("pop_valid", 32'(v_o[0]), 32'd0);

        do_reset();
        for (int i = 0; i < 8; i++) begin
            rnd_rec();
            txnid = 12'(i);
            cyc(1, 0);
        end
        chk("full_cnt", 32'(c_o[0]), 32'd8);
        chk("full_ready", 32'(r_o[0]), 32'd0);
        rnd_rec();
        cyc(1, 0);
        chk("drop_err", 32'(e_o[0]), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("order_txnid", 32'(f_o[0][16:5]), 32'(i));
            cyc(0, 1);
        end

        do_reset();
        for (int i = 0; i < 3; i++) begin
            rnd_rec();
            cyc(1, 0);
        end
        for (int i = 0; i < 20; i++) begin
            rnd_rec();
            cyc(1, 1);
        end
        chk("steady_cnt", 32'(c_o[0]), 32'd3);

        do_reset();
        for (int i = 0; i < 8; i++) begin
            rnd_rec();
            cyc(1, 0);
        end
        rnd_rec();
        cyc(1, 1);
        chk("fullpop_cnt", 32'(c_o[0]), 32'd7);
        chk("fullpop_ready", 32'(r_o[0]), 32'd1);
        chk("fullpop_err", 32'(e_o[0]), 32'd1);

        do_reset();
        for (int i = 0; i < 12; i++) begin
            rnd_rec();
            cyc(1, i > 0);
        end
        for (int i = 0; i < 6; i++)
            cyc(0, 1);
        chk("d5_empty_cnt", 32'(c_o[1]), 32'd0);
        cyc(0, 1);
        chk("d5_won_empty_err", 32'(e_o[1]), 32'd1);
        chk("d5_won_empty_cnt", 32'(c_o[1]), 32'd0);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            rnd_rec();
            cyc(1, 0);
        end
        chk_all();
        #3;
        rst = 1'b1;
        model_clear();
        #1;
        chk("arst_valid", 32'(v_o[0]), 32'd0);
        chk("arst_cnt", 32'(c_o[0]), 32'd0);
        chk("arst_ready", 32'(r_o[0]), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_rec(4'hA, 11'h7FF, 12'hBEE, 4'h6, 1'b0);
        cyc(1, 0);
        chk("arst_newhead", f_o[0], {4'hA, 11'h7FF, 12'hBEE, 4'h6, 1'b0});

        do_reset();
        for (int i = 0; i < 400; i++) begin
            rnd_rec();
            cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50);
        end
        chk_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
